// File: rtl/tb_dina_seq_map.sv
// tb_dina_seq_map: maps CB/TBB lane words and sequenced vt scalars onto the TB port-A write data.
module tb_dina_seq_map #(
  parameter int L = 4,
  parameter int RSA_DW = 32,
  parameter int SEL_DW = 5,
  parameter int NV = 2,
  parameter int OFF_DW = (L / 2 > 1) ? $clog2(L / 2) : 1
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_DW-1:0]      in_sel,
  input  logic [OFF_DW-1:0]      l_k_off,
  input  logic [L*RSA_DW-1:0]    src_cb,
  input  logic [L*RSA_DW-1:0]    src_tbb,
  input  logic [NV*RSA_DW-1:0]   vt,
  output logic [L*RSA_DW-1:0]    TB_dina,
  output logic                   out_valid
);
  localparam int CW = NV > 1 ? $clog2(NV) : 1;
  localparam int MW = SEL_DW - 2;
  localparam logic [MW-1:0] M_CB = MW'(3'b100);
  localparam logic [MW-1:0] M_TBB = MW'(3'b101);
  localparam logic [MW-1:0] M_UPD = MW'(3'b111);
  typedef enum logic {IDLE, SEQ} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [L-1:0][RSA_DW-1:0] cb, tbb, word;
  logic [NV-1:0][RSA_DW-1:0] vtv, snap;
  logic [MW-1:0] mode;
  logic [1:0] dir;
  logic wv;
  assign cb = src_cb;
  assign tbb = src_tbb;
  assign vtv = vt;
  assign mode = in_sel[SEL_DW-1:2];
  assign dir = in_sel[1:0];
  assign in_ready = state == IDLE;
  always_comb begin
    word = '0;
    wv = 1'b0;
    state_nxt = state;
    cnt_nxt = cnt;
    if (state == SEQ) begin
      wv = 1'b1;
      word[0] = snap[cnt];
      state_nxt = (cnt == CW'(NV - 1)) ? IDLE : SEQ;
      cnt_nxt = (cnt == CW'(NV - 1)) ? '0 : cnt + 1'b1;
    end else if (in_valid) begin
      wv = 1'b1;
      if (mode == M_UPD) begin
        // lane 0 comes straight from vt; the snapshot only feeds the later words
        word[0] = vtv[0];
        if (NV > 1) begin
          state_nxt = SEQ;
          cnt_nxt = CW'(1);
        end
      end else if (mode == M_TBB) begin
        word = tbb;
      end else if (mode == M_CB) begin
        // an out-of-range NEW offset matches no lane and yields an all-zero word
        for (int i = 0; i < L; i++)
          word[i] = dir == 2'b01 ? cb[i] :
                    dir == 2'b10 ? cb[L-1-i] :
                    (dir == 2'b11 && i == 2 * int'(l_k_off)) ? cb[0] :
                    (dir == 2'b11 && i == 2 * int'(l_k_off) + 1) ? cb[1] : '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt <= '0;
      snap <= '0;
      TB_dina <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      out_valid <= wv;
      if (wv) TB_dina <= word;
      if (in_valid && in_ready && mode == M_UPD) snap <= vtv;
    end
  end
endmodule

// File: tb/tb_tb_dina_seq_map.sv
// tb_tb_dina_seq_map: directed and random checks of tb_dina_seq_map against a queue-based word model.
module tb_tb_dina_seq_map;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sys_rst = 1'b1, in_valid = 1'b0, in_ready, out_valid;
  logic [4:0] in_sel = '0;
  logic l_k_off = 1'b0;
  logic [127:0] src_cb = '0, src_tbb = '0, TB_dina;
  logic [63:0] vt = '0;
  logic v6 = 1'b0, rdy6, ov6;
  logic [4:0] sel6 = '0;
  logic [1:0] off6 = '0;
  logic [191:0] cb6 = '0, d6;
  int checks = 0, passed = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_exp = '0;

  tb_dina_seq_map dut (
    .clk(clk), .sys_rst(sys_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .l_k_off(l_k_off), .src_cb(src_cb), .src_tbb(src_tbb),
    .vt(vt), .TB_dina(TB_dina), .out_valid(out_valid)
  );

  tb_dina_seq_map #(.L(6)) u6 (
    .clk(clk), .sys_rst(sys_rst), .in_valid(v6), .in_ready(rdy6),
    .in_sel(sel6), .l_k_off(off6), .src_cb(cb6), .src_tbb(192'd0),
    .vt(64'd0), .TB_dina(d6), .out_valid(ov6)
  );

  function automatic logic [127:0] lanes4(input int a, input int b, input int c, input int d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  // expected word for a single-word request on the L=4 instance
  function automatic logic [127:0] calc(input logic [4:0] s, input logic o,
                                        input logic [127:0] c, input logic [127:0] t);
    logic [127:0] r;
    r = '0;
    if (s[4:2] == 3'b101) r = t;
    else if (s[4:2] == 3'b100) begin
      if (s[1:0] == 2'b01) r = c;
      else if (s[1:0] == 2'b10) for (int i = 0; i < 4; i++) r[32*i +: 32] = c[32*(3-i) +: 32];
      else if (s[1:0] == 2'b11) r[64*o +: 64] = c[63:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // one clock of the main instance: model the accept, then check the registered outputs
  task automatic cyc(input string tag);
    chk({tag, ".rdy"}, in_ready, exp_q.size() == 0);
    if (in_valid && exp_q.size() == 0) begin
      if (in_sel[4:2] == 3'b111)
        for (int k = 0; k < 2; k++) exp_q.push_back({96'd0, vt[32*k +: 32]});
      else exp_q.push_back(calc(in_sel, l_k_off, src_cb, src_tbb));
    end
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      chk({tag, ".ov"}, out_valid, 1);
    end else chk({tag, ".ov"}, out_valid, 0);
    chk({tag, ".d"}, TB_dina, last_exp);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    in_valid = 1'b0;
    v6 = 1'b0;
    @(posedge clk); #1;
    chk("rst.d", TB_dina, 0);
    chk("rst.ov", out_valid, 0);
    chk("rst.rdy", in_ready, 1);
    chk("rst.ov6", ov6, 0);
    exp_q.delete();
    last_exp = '0;
    sys_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    in_valid = 1'b1;
    in_sel = 5'b10001;
    src_cb = lanes4(1, 2, 3, 4);
    cyc("pos");
    chk("pos.abs", TB_dina, lanes4(1, 2, 3, 4));
    in_sel = 5'b10010;
    cyc("neg");
    chk("neg.abs", TB_dina, lanes4(4, 3, 2, 1));
    in_sel = 5'b10011;
    src_cb = lanes4('hA, 'hB, 'h77, 'h88);
    l_k_off = 1'b0;
    cyc("new0");
    chk("new0.abs", TB_dina, lanes4('hA, 'hB, 0, 0));
    l_k_off = 1'b1;
    cyc("new1");
    chk("new1.abs", TB_dina, lanes4(0, 0, 'hA, 'hB));
    in_valid = 1'b0;
    v6 = 1'b1;
    sel6 = 5'b10011;
    cb6 = {128'd0, 32'hB, 32'hA};
    off6 = 2'd2;
    @(posedge clk); #1;
    chk("l6.new2", d6, {32'hB, 32'hA, 128'd0});
    chk("l6.ov2", ov6, 1);
    off6 = 2'd3;
    @(posedge clk); #1;
    chk("l6.new3", d6, 0);
    chk("l6.ov3", ov6, 1);
    v6 = 1'b0;
    exp_q.delete();
    cyc("idle0");
    in_valid = 1'b1;
    in_sel = 5'b11100;
    vt = {32'd7, -32'sd5};
    cyc("upd.a");
    chk("upd.w0", TB_dina, lanes4(-5, 0, 0, 0));
    in_valid = 1'b0;
    vt = {32'd9, 32'd9};
    cyc("upd.b");
    chk("upd.w1", TB_dina, lanes4(7, 0, 0, 0));
    cyc("upd.c");
    in_valid = 1'b1;
    in_sel = 5'b11100;
    vt = {32'd7, -32'sd5};
    cyc("b2b.a");
    in_sel = 5'b10101;
    src_tbb = lanes4(8, 8, 8, 8);
    cyc("b2b.b");
    cyc("b2b.c");
    chk("b2b.tbb", TB_dina, lanes4(8, 8, 8, 8));
    in_sel = 5'b11100;
    cyc("abort.a");
    do_reset();
    cyc("abort.b");
    in_valid = 1'b1;
    in_sel = 5'b10001;
    src_cb = lanes4(5, 6, 7, 8);
    cyc("hold.w");
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) cyc("hold");
    chk("hold.abs", TB_dina, lanes4(5, 6, 7, 8));
    in_valid = 1'b1;
    in_sel = 5'b11000;
    cyc("inv");
    chk("inv.abs", TB_dina, 0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      in_valid = $urandom_range(0, 3) != 0;
      in_sel = 5'($urandom);
      l_k_off = 1'($urandom);
      src_cb = {$urandom, $urandom, $urandom, $urandom};
      src_tbb = {$urandom, $urandom, $urandom, $urandom};
      vt = {$urandom, $urandom};
      cyc("rnd");
    end
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
